// File: rtl/cycle_count_display_if.sv
// rtl/cycle_count_display_if.sv - load/status handshake between the cycle counter and the display driver
//
// Purpose: bundles the count hand-off so producer and display connect with one port.
// Signals:
//   count_in [31:0]  unsigned cycle count offered to the display
//   load             capture strobe, honoured only while the display is idle
//   busy             conversion in progress
//   done             one-cycle pulse when a new value reaches the display
// Modports: master = count producer, slave = display driver.

interface cycle_count_display_if;
  logic [31:0] count_in;
  logic        load;
  logic        busy;
  logic        done;

  modport master (
    output count_in,
    output load,
    input  busy,
    input  done
  );

  modport slave (
    input  count_in,
    input  load,
    output busy,
    output done
  );
endinterface

// File: rtl/cycle_count_display.sv
// rtl/cycle_count_display.sv - eight-digit multiplexed seven-segment driver for the cycle count
//
// Purpose: captures a 32-bit count, converts it to BCD with a one-iteration-per-clock
// double-dabble engine, and scans the eight digits onto common-anode displays with
// leading-zero blanking and an overflow dash pattern.
// Build option: define DISPLAY_HEX_EN to drop the BCD engine and show the raw count in hex
// (single-cycle load, hex glyphs, overflow never set).
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   host           cycle_count_display_if.slave (count_in, load, busy, done)
//   an   [7:0]     digit enables, active-low, an[0] = least-significant digit
//   seg  [6:0]     {g,f,e,d,c,b,a}, active-low
//   dp             decimal point, active-low, held off

module cycle_count_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  cycle_count_display_if.slave         host,
  output logic [7:0]                   an,
  output logic [6:0]                   seg,
  output logic                         dp
);

  localparam int             DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

`ifndef DISPLAY_HEX_EN
  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LATCH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [39:0] bcd_adj;
  logic [5:0]  iter_q, iter_d;
`endif

  logic [31:0]      disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       digit_q, digit_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       nibble;
  logic             blank;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
`ifdef DISPLAY_HEX_EN
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      4'hF:    glyph = 7'h0E;
`endif
      default: glyph = 7'h7F;
    endcase
  endfunction

  always_comb begin
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div_d   = div_q;
    digit_d = digit_q;
    an_d    = an_q;
    seg_d   = seg_q;
    nibble  = 4'h0;
    blank   = 1'b0;

`ifdef DISPLAY_HEX_EN
    busy_d = 1'b0;
    ovf_d  = 1'b0;
    if (host.load) begin
      disp_d = host.count_in;
      done_d = 1'b1;
    end
`else
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    bcd_adj = bcd_q;

    // Per-nibble +3 correction; nibbles never carry into each other.
    for (int i = 0; i < 10; i++) begin
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + ((bcd_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end

    case (state_q)
      IDLE: begin
        if (host.load) begin
          bin_d   = host.count_in;
          bcd_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d  = {bcd_adj[38:0], bin_q[31]};
        bin_d  = {bin_q[30:0], 1'b0};
        iter_d = iter_q + 6'd1;
        // The 32nd shift happens on this edge; done is raised while in LATCH.
        if (iter_q == 6'd31) begin
          state_d = LATCH;
          done_d  = 1'b1;
        end
      end
      LATCH: begin
        disp_d  = bcd_q[31:0];
        ovf_d   = |bcd_q[39:32];
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
`endif

    // Free-running scan, independent of the conversion.
    if (div_q == DIV_LAST) begin
      div_d   = '0;
      digit_d = digit_q + 3'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // Glyph is built from the next-state digit/value so an and seg move together.
    an_d   = ~(8'b1 << digit_d);
    nibble = disp_d[{digit_d, 2'b00} +: 4];
    blank  = (digit_d != 3'd0) && ((disp_d >> {digit_d, 2'b00}) == 32'd0);
    if (ovf_d) begin
      seg_d = 7'h3F;
    end else if (blank) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = glyph(nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifndef DISPLAY_HEX_EN
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
`endif
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
      digit_q <= '0;
      an_q    <= 8'hFE;
      seg_q   <= 7'h40;
    end else begin
`ifndef DISPLAY_HEX_EN
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
`endif
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div_q   <= div_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign host.busy = busy_q;
  assign host.done = done_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;

endmodule

// File: tb/tb_cycle_count_display.sv
// tb/tb_cycle_count_display.sv - scoreboard bench for cycle_count_display

module tb_cycle_count_display;

  localparam int SCAN_DIV = 4;
`ifdef DISPLAY_HEX_EN
  localparam int       EXP_LAT  = 0;
  localparam logic     EXP_BUSY = 1'b0;
`else
  localparam int       EXP_LAT  = 32;
  localparam logic     EXP_BUSY = 1'b1;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_pass   = 0;

  logic [55:0] sb [$];

  cycle_count_display_if bus ();

  cycle_count_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] ref_glyph(input int n);
    case (n)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected seg pattern for all eight digits, digit k at bits [7k+6:7k].
  function automatic logic [55:0] model(input logic [31:0] v);
    logic [55:0] r;
    longint      rest;
    r = '0;
`ifdef DISPLAY_HEX_EN
    for (int k = 0; k < 8; k++) begin
      rest = longint'(v) >> (4 * k);
      if (k > 0 && rest == 0) r[7*k +: 7] = 7'h7F;
      else                    r[7*k +: 7] = ref_glyph(int'(rest % 16));
    end
`else
    rest = longint'(v);
    for (int k = 0; k < 8; k++) begin
      if (v >= 32'd100000000)        r[7*k +: 7] = 7'h3F;
      else if (k > 0 && rest == 0)   r[7*k +: 7] = 7'h7F;
      else                           r[7*k +: 7] = ref_glyph(int'(rest % 10));
      rest = rest / 10;
    end
`endif
    return r;
  endfunction

  task automatic start_load(input logic [31:0] v, input bit push);
    @(negedge clk);
    bus.count_in = v;
    bus.load     = 1'b1;
    if (push) sb.push_back(model(v));
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    check("busy_after_load", bus.busy, EXP_BUSY);
  endtask

  task automatic wait_done(inout int lat);
    while (bus.done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.done !== 1'b1) check("done_timeout", bus.done, 1'b1);
  endtask

  task automatic check_display(input logic [55:0] exp);
    logic [7:0] want;
    int         n;
    for (int k = 0; k < 8; k++) begin
      want = ~(8'(1) << k);
      n = 0;
      while (an !== want && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      check($sformatf("an%0d", k), an, want);
      check($sformatf("seg%0d", k), seg, exp[7*k +: 7]);
    end
    check("dp", dp, 1'b1);
  endtask

  task automatic finish_load(input int lat);
    check("latency", lat, EXP_LAT);
    @(posedge clk);
    #1;
    check("done_one_cycle", bus.done, 1'b0);
    check("busy_idle", bus.busy, 1'b0);
    if (sb.size() == 0) check("sb_empty", sb.size(), 1);
    else check_display(sb.pop_front());
  endtask

  task automatic run_load(input logic [31:0] v);
    int lat;
    start_load(v, 1'b1);
    lat = 0;
    wait_done(lat);
    finish_load(lat);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) n++;
    end
  endtask

  initial begin
    int lat;
    int nd;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.count_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_an", an, 8'hFE);
    check("rst_seg", seg, 7'h40);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_dp", dp, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("scan1_an", an, 8'hFD);
    check("scan1_seg", seg, 7'h7F);

`ifdef DISPLAY_HEX_EN
    run_load(32'hDEADBEEF);
    run_load(32'h00001234);
    run_load(32'h0);
`else
    run_load(32'd1234);
    run_load(32'd99999999);
    run_load(32'd100000000);
    run_load(32'd0);

    // Second load while busy is ignored.
    start_load(32'd5, 1'b1);
    lat = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    bus.count_in = 32'd7;
    bus.load     = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    lat++;
    wait_done(lat);
    finish_load(lat);
    count_done(40, nd);
    check("no_extra_done", nd, 0);

    // Reset mid-conversion discards the partial result.
    start_load(32'd99, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_an", an, 8'hFE);
    check("midrst_seg", seg, 7'h40);
    check("midrst_busy", bus.busy, 1'b0);
    count_done(40, nd);
    check("midrst_no_done", nd, 0);
    run_load(32'd42);
`endif

    // rst and load together: rst wins.
    @(negedge clk);
    rst          = 1'b1;
    bus.load     = 1'b1;
    bus.count_in = 32'd777;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    bus.load = 1'b0;
    check("rstload_busy", bus.busy, 1'b0);
    check("rstload_done", bus.done, 1'b0);
    count_done(40, nd);
    check("rstload_no_done", nd, 0);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cycle_count_display.md
# cycle_count_display

Eight-digit seven-segment display driver for the cycle-count result. It accepts a 32-bit count with a load strobe and converts it to BCD with a sequential double-dabble engine (one iteration per clock). It then time-multiplexes the digits onto common-anode, active-low displays with leading-zero blanking and an overflow indicator. It sits downstream of the cycle counter and is the consumer end of its count output.

## Interface
Parameters:
- SCAN_DIV, default 50000: clk cycles each digit stays enabled; must be ≥ 2.

Ports:
- clk  in  1: system clock.
- rst  in  1: reset, synchronous, active-high.
- count_in  in  32: unsigned cycle count to display.
- load  in  1: sampled high in IDLE, captures count_in and starts conversion.
- busy  out  1: conversion in progress.
- done  out  1: one-cycle pulse when a new value is latched to the display.
- an  out  8: digit enables, active-low; an[0] is the least-significant digit.
- seg  out  7: {g,f,e,d,c,b,a}, active-low.
- dp  out  1: decimal point, active-low; constant 1 (off).

## Operation
- FSM states: IDLE, CONVERT, LATCH.
- IDLE + load=1:
  - bin ← count_in, bcd[39:0] ← 0, iter ← 0.
  - Next state CONVERT.
- CONVERT, each cycle:
  - Every bcd nibble ≥ 5 gets +3 (4-bit add, no carry between nibbles).
  - Then {bcd,bin} shifts left by 1; iter increments.
  - After iter reaches 32, next state LATCH.
- LATCH:
  - disp[31:0] ← bcd[31:0]; ovf ← (bcd[39:32] != 0).
  - done=1 for this cycle only; next state IDLE.
- load is ignored in CONVERT and LATCH; there is no queueing.
- busy=1 in CONVERT and LATCH, 0 in IDLE.
- The display holds the previous value until LATCH.
- Scan:
  - divider counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index d increments 0..7, then wraps to 0.
  - an = ~(8'b1 << d).
- Glyph for digit d:
  - ovf=1: '-' (7'h3F) on all eight digits.
  - Otherwise, blank (7'h7F) if d > 0 and disp nibbles d..7 are all zero (leading-zero blanking; digit 0 is always shown).
  - Otherwise, the decimal glyph: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Values up to 99,999,999 display exactly. Values ≥ 100,000,000 set ovf.

## Timing
- Reset values:
  - state IDLE, busy 0, done 0.
  - disp 0, ovf 0, d 0, divider 0.
  - an 8'hFE, seg 7'h40, dp 1.
- Conversion latency:
  - load sampled at edge t0; iterations occur on edges t0+1..t0+32.
  - LATCH is entered at edge t0+32; disp updates and done falls at edge t0+33.
  - done is high for exactly one cycle, between edges t0+32 and t0+33.
  - busy is high from t0+1 through t0+33.
  - A new load is accepted at edge t0+33 at the earliest.
- an and seg are registered and change together, only on a divider wrap or a disp/ovf update.
- The scan runs independently of the FSM; conversion never stalls the scan.
- rst mid-CONVERT or mid-LATCH: return to IDLE with the reset values above. No done pulse; the partial result is discarded.
- rst and load in the same cycle: rst wins.

## Configuration
- DISPLAY_HEX_EN defined:
  - The BCD engine is removed.
  - load in IDLE writes disp ← count_in at the next edge; done pulses in the following cycle (latency 1); busy stays 0.
  - Digits use hex glyphs; additional glyphs A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - ovf is held 0. Leading-zero blanking is unchanged.
- Not defined: decimal operation as above.

## Test plan
- Reset with SCAN_DIV=4 → an=8'hFE, seg=7'h40, busy=0, done=0. After 4 cycles, an=8'hFD, seg=7'h7F.
- load count_in=32'd1234 → busy from the next cycle; done exactly 33 edges after load. Digits 0..3 show 4,3,2,1 (19,30,24,79); digits 4..7 show 7'h7F.
- count_in=32'd99999999 → all eight digits 7'h10. count_in=32'd100000000 → all digits 7'h3F.
- load 32'd5, then load 32'd7 at t0+10 while busy → single done pulse; digit 0 shows 7'h12 (5).
- rst pulsed at t0+15 → no done pulse; an=8'hFE, seg=7'h40. A fresh load of 32'd42 completes normally.
- With DISPLAY_HEX_EN: load 32'hDEADBEEF → done one cycle later. Digits 0..7 show F,E,E,B,D,A,E,D with the hex glyphs above.
